// File: rtl/neuron_stream_driver_pkg.sv
// rtl/neuron_stream_driver_pkg.sv - shared types and helpers for the neuron stream driver
//
// Purpose: FSM state encoding, default geometry and index-width derivation
//          shared by neuron_stream_driver and neuron_input_buffer.
// Ports:   none (package).

package neuron_stream_driver_pkg;

  localparam int N_DEFAULT = 10;
  localparam int Q_DEFAULT = 9;
  localparam int K_DEFAULT = 4;

  typedef enum logic [2:0] {
    S_LOAD     = 3'd0,
    S_PREFETCH = 3'd1,
    S_STREAM   = 3'd2,
    S_BIAS     = 3'd3,
    S_CAPTURE  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Index width for a K-entry vector; never narrower than one bit.
  function automatic int addr_width(input int k);
    return (k < 2) ? 1 : clog2(k);
  endfunction

endpackage

// File: rtl/neuron_input_buffer.sv
// rtl/neuron_input_buffer.sv - K x N input vector register file
//
// Purpose: holds the K input elements of the current vector; written in
//          order during load, read combinationally by stream index.
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write index
//   i_wdata  in   write data (N bits)
//   i_raddr  in   read index
//   o_rdata  out  read data (N bits), combinational

module neuron_input_buffer
  import neuron_stream_driver_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int K  = K_DEFAULT,
  parameter int AW = addr_width(K)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [N-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [N-1:0]  o_rdata
);

  // Data storage only: stale contents are harmless because the load
  // counter restarts at zero and every entry is rewritten before use.
  logic [N-1:0] r_mem [K];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/neuron_stream_driver.sv
// rtl/neuron_stream_driver.sv - sequencer feeding one fixed-point MAC neuron
//
// Purpose: buffers a K-element input vector, streams K weight/input pairs
//          from a 1-cycle-latency weight ROM into the neuron, runs the
//          neuron's bias cycle, captures its result and offers it on a
//          valid/ready output.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input word handshake
//   in_data               input element x[i], loaded i=0..K-1
//   bias                  neuron bias, sampled with the last input word
//   w_addr / w_data       weight ROM address / data (1-cycle latency)
//   n_rst, n_inptReady    neuron reset and accumulate strobe
//   n_w, n_x, n_b         neuron weight, input and bias operands
//   n_out                 neuron result (combinational from accumulator)
//   out_valid/out_ready   result handshake
//   out_data              captured neuron result

module neuron_stream_driver
  import neuron_stream_driver_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int Q  = Q_DEFAULT,
  parameter int K  = K_DEFAULT,
  parameter int AW = addr_width(K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [N-1:0]  bias,
  output logic [AW-1:0] w_addr,
  input  logic [N-1:0]  w_data,
  output logic          n_rst,
  output logic          n_inptReady,
  output logic [N-1:0]  n_w,
  output logic [N-1:0]  n_x,
  output logic [N-1:0]  n_b,
  input  logic [N-1:0]  n_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data
);

  // Q only matters to the neuron; it is checked here so a bad pairing of
  // word width and fraction bits is caught at elaboration.
  if (Q < 0 || Q >= N) begin : g_bad_q
    $error("neuron_stream_driver: Q must be in [0, N-1]");
  end
  if (K < 2) begin : g_bad_k
    $error("neuron_stream_driver: K must be at least 2");
  end

  localparam logic [AW-1:0] LAST = AW'(K - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] r_idx;
  logic [N-1:0]  r_bias;
  logic [N-1:0]  r_out_data;
  logic          r_out_valid;
  logic [AW-1:0] r_w_addr;
  logic          r_n_rst;
  logic          r_n_inptReady;

  logic          w_accept;
  logic [N-1:0]  w_xbuf_rdata;

  assign in_ready = (r_state == S_LOAD) && !rst;
  assign w_accept = in_valid && in_ready;

  neuron_input_buffer #(
    .N  (N),
    .K  (K),
    .AW (AW)
  ) u_xbuf (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_cnt),
    .i_wdata (in_data),
    .i_raddr (r_idx),
    .o_rdata (w_xbuf_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_LOAD;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_bias        <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_w_addr      <= '0;
      r_n_rst       <= 1'b1;
      r_n_inptReady <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            if (r_cnt == LAST) begin
              r_bias   <= bias;
              r_cnt    <= '0;
              r_w_addr <= '0;
              r_state  <= S_PREFETCH;
            end else begin
              r_cnt <= r_cnt + ONE;
            end
          end
        end
        // Address 0 is on the ROM this cycle, so weight 0 is on w_data
        // in the first stream cycle; from then on the address runs one
        // ahead of the index.
        S_PREFETCH: begin
          r_idx         <= '0;
          r_w_addr      <= ONE;
          r_n_rst       <= 1'b0;
          r_n_inptReady <= 1'b1;
          r_state       <= S_STREAM;
        end
        S_STREAM: begin
          if (r_idx == LAST) begin
            r_idx         <= '0;
            r_w_addr      <= '0;
            r_n_inptReady <= 1'b0;
            r_state       <= S_BIAS;
          end else begin
            r_idx <= r_idx + ONE;
            if (r_w_addr != LAST) r_w_addr <= r_w_addr + ONE;
          end
        end
        // Neuron out of reset with strobe low: it adds n_b at this edge.
        S_BIAS: begin
          r_state <= S_CAPTURE;
        end
        // The neuron would add bias again at this closing edge; the result
        // is sampled before that and the neuron is reset from DONE onward.
        S_CAPTURE: begin
          r_out_data  <= n_out;
          r_out_valid <= 1'b1;
          r_n_rst     <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_LOAD;
          end
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  assign w_addr      = r_w_addr;
  assign n_rst       = r_n_rst;
  assign n_inptReady = r_n_inptReady;
  assign n_w         = r_n_inptReady ? w_data : '0;
  assign n_x         = r_n_inptReady ? w_xbuf_rdata : '0;
  assign n_b         = r_bias;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;

endmodule

// File: tb/tb_neuron_stream_driver.sv
// tb/tb_neuron_stream_driver.sv - directed self-checking bench for neuron_stream_driver

module tb_neuron_stream_driver;

  localparam int N  = 10;
  localparam int Q  = 9;
  localparam int K  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [N-1:0]  bias;
  logic [AW-1:0] w_addr;
  logic [N-1:0]  w_data = '0;
  logic          n_rst;
  logic          n_inptReady;
  logic [N-1:0]  n_w;
  logic [N-1:0]  n_x;
  logic [N-1:0]  n_b;
  logic [N-1:0]  n_out;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;

  logic [N-1:0]        rom [K];
  logic [N-1:0]        acc = '0;
  logic signed [2*N-1:0] prod;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  neuron_stream_driver #(.N(N), .Q(Q), .K(K), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .bias        (bias),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .n_rst       (n_rst),
    .n_inptReady (n_inptReady),
    .n_w         (n_w),
    .n_x         (n_x),
    .n_b         (n_b),
    .n_out       (n_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
  );

  // Weight ROM with one cycle of read latency.
  always @(posedge clk) w_data <= rom[w_addr];

  // Reference neuron: Q-format MAC, truncating, bias add when idle and out of reset.
  assign prod = $signed(n_w) * $signed(n_x);
  always @(posedge clk) begin
    if (n_rst)            acc <= '0;
    else if (n_inptReady) acc <= acc + prod[Q +: N];
    else                  acc <= acc + n_b;
  end
  assign n_out = acc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_vector(input logic [N-1:0] x [K], input logic [N-1:0] b, input bit bursty);
    int  i = 0;
    int  cyc = 0;
    bit  accepted;
    while (i < K && cyc < 200) begin
      in_valid = bursty ? (cyc % 3 == 0) : 1'b1;
      in_data  = in_valid ? x[i] : 10'h1FF;
      bias     = (i == K - 1) ? b : 10'h155;
      accepted = in_valid && in_ready;
      @(posedge clk); #1;
      if (accepted) i++;
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    bias     = 10'h2AA;
    if (cyc >= 200) check_eq("load_timeout", 32'(i), 32'(K));
  endtask

  task automatic wait_result(input string tag, input logic [N-1:0] exp_data);
    int n = 0;
    int ready_seen = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (in_ready) ready_seen++;
    end
    check_eq({tag, "_latency"}, 32'(n), 32'(K + 3));
    check_eq({tag, "_in_ready_busy"}, 32'(ready_seen), 32'd0);
    check_eq({tag, "_out_data"}, 32'(out_data), 32'(exp_data));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_back_to_load"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_n_rst_idle"}, 32'(n_rst), 32'd1);
  endtask

  logic [N-1:0] xv [K];
  logic [N-1:0] held;
  int bad_valid, bad_data, bad_ready, bad_strobe;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; bias = '0; out_ready = 1'b0;
    for (int k = 0; k < K; k++) rom[k] = 10'd128;
    for (int k = 0; k < K; k++) xv[k] = 10'd256;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_n_rst", 32'(n_rst), 32'd1);
    check_eq("rst_n_inptReady", 32'(n_inptReady), 32'd0);
    check_eq("rst_w_addr", 32'(w_addr), 32'd0);
    check_eq("rst_n_w", 32'(n_w), 32'd0);
    check_eq("rst_n_x", 32'(n_x), 32'd0);
    check_eq("rst_n_b", 32'(n_b), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic: 4 x (0.5 * 0.25) + 64 -> 320
    send_vector(xv, 10'd64, 1'b0);
    check_eq("basic_bias_latched", 32'(n_b), 32'd64);
    check_eq("basic_prefetch_addr", 32'(w_addr), 32'd0);
    wait_result("basic", 10'd320);

    // Backpressure: hold for 20 cycles
    held = out_data;
    bad_valid = 0; bad_data = 0; bad_ready = 0; bad_strobe = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1) bad_valid++;
      if (out_data !== held) bad_data++;
      if (in_ready !== 1'b0) bad_ready++;
      if (n_inptReady !== 1'b0) bad_strobe++;
    end
    check_eq("bp_valid_held", 32'(bad_valid), 32'd0);
    check_eq("bp_data_held", 32'(bad_data), 32'd0);
    check_eq("bp_in_ready_low", 32'(bad_ready), 32'd0);
    check_eq("bp_strobe_low", 32'(bad_strobe), 32'd0);
    consume("bp");

    // Back-to-back negative: 4 x (0.5 * -0.25) + 0 -> -256 (0x300)
    for (int k = 0; k < K; k++) rom[k] = 10'h380;
    check_eq("b2b_n_out_cleared", 32'(n_out), 32'd0);
    send_vector(xv, 10'd0, 1'b0);
    wait_result("neg", 10'h300);
    consume("neg");

    // Reset in the middle of STREAM at idx=2
    for (int k = 0; k < K; k++) rom[k] = 10'd128;
    send_vector(xv, 10'd64, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_stream_strobe", 32'(n_inptReady), 32'd1);
    check_eq("mid_stream_w_addr", 32'(w_addr), 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("mid_rst_n_rst", 32'(n_rst), 32'd1);
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_strobe", 32'(n_inptReady), 32'd0);
    send_vector(xv, 10'd64, 1'b0);
    wait_result("after_rst", 10'd320);
    consume("after_rst");

    // Bursty input with garbage on idle cycles
    send_vector(xv, 10'd64, 1'b1);
    wait_result("bursty", 10'd320);
    consume("bursty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
